// File: rtl/switch_perf_counters.sv
// rtl/switch_perf_counters.sv - per-queue packet latency/flit statistics with a one-cycle read port
module switch_perf_counters #(
    parameter int NUM_BUFFERS = 2,
    parameter int NUM_VCS     = 2,
    parameter int LAT_WIDTH   = 16,
    parameter int CNT_WIDTH   = 32,
    localparam int N  = NUM_VCS * NUM_BUFFERS,
    localparam int BW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [N-1:0]         not_idle,
    input  logic [N-1:0]         flit_sent,
    input  logic                 clear_req,
    input  logic                 rd_req,
    input  logic [BW-1:0]        rd_buf,
    input  logic [2:0]           rd_sel,
    output logic                 rd_valid,
    output logic [CNT_WIDTH-1:0] rd_data,
    output logic                 rd_err
);

    localparam logic [LAT_WIDTH-1:0] LAT_MAX = '1;

    logic [N-1:0]         prev_not_idle;
    logic [N-1:0]         end_pkt;
    logic [LAT_WIDTH-1:0] lat_cnt  [N];
    logic [LAT_WIDTH-1:0] flit_cnt [N];
    logic [CNT_WIDTH-1:0] packets  [N];
    logic [CNT_WIDTH-1:0] flit_sum [N];
    logic [CNT_WIDTH-1:0] lat_sum  [N];
    logic [LAT_WIDTH-1:0] lat_min  [N];
    logic [LAT_WIDTH-1:0] lat_max  [N];

    logic                 rd_bad;
    logic [CNT_WIDTH-1:0] rd_mux;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    endfunction

    assign end_pkt = prev_not_idle & ~not_idle;

    // A packet ends on the falling edge of not_idle; zero-flit ends are bank claims and record nothing.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            prev_not_idle <= '0;
            for (int i = 0; i < N; i++) begin
                lat_cnt[i]  <= '0;
                flit_cnt[i] <= '0;
                packets[i]  <= '0;
                flit_sum[i] <= '0;
                lat_sum[i]  <= '0;
                lat_min[i]  <= '1;
                lat_max[i]  <= '0;
            end
        end else begin
            prev_not_idle <= not_idle;
            for (int i = 0; i < N; i++) begin
                if (end_pkt[i]) begin
                    lat_cnt[i]  <= '0;
                    flit_cnt[i] <= '0;
                end else begin
                    if (not_idle[i] && lat_cnt[i] != LAT_MAX)
                        lat_cnt[i] <= lat_cnt[i] + 1'b1;
                    if (flit_sent[i] && flit_cnt[i] != LAT_MAX)
                        flit_cnt[i] <= flit_cnt[i] + 1'b1;
                end

                if (clear_req) begin
                    packets[i]  <= '0;
                    flit_sum[i] <= '0;
                    lat_sum[i]  <= '0;
                    lat_min[i]  <= '1;
                    lat_max[i]  <= '0;
                end else if (end_pkt[i] && flit_cnt[i] != '0) begin
                    packets[i]  <= sat_add(packets[i], CNT_WIDTH'(1));
                    flit_sum[i] <= sat_add(flit_sum[i], CNT_WIDTH'(flit_cnt[i]));
                    lat_sum[i]  <= sat_add(lat_sum[i], CNT_WIDTH'(lat_cnt[i]));
                    if (lat_cnt[i] > lat_max[i])
                        lat_max[i] <= lat_cnt[i];
                    if (lat_cnt[i] < lat_min[i])
                        lat_min[i] <= lat_cnt[i];
                end
            end
        end
    end

    always_comb begin
        rd_bad = (32'(rd_buf) >= N) || (rd_sel > 3'd4);
        rd_mux = '0;
        if (!rd_bad) begin
            case (rd_sel)
                3'd0:    rd_mux = packets[rd_buf];
                3'd1:    rd_mux = flit_sum[rd_buf];
                3'd2:    rd_mux = lat_sum[rd_buf];
                3'd3:    rd_mux = CNT_WIDTH'(lat_min[rd_buf]);
                3'd4:    rd_mux = CNT_WIDTH'(lat_max[rd_buf]);
                default: rd_mux = '0;
            endcase
        end
    end

    // Response samples the statistics before this cycle's updates land.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            rd_data  <= rd_req ? rd_mux : '0;
            rd_err   <= rd_req & rd_bad;
        end
    end

endmodule

// File: tb/tb_switch_perf_counters.sv
// tb/tb_switch_perf_counters.sv - directed table-driven bench for switch_perf_counters
module tb_switch_perf_counters;

    localparam int NB = 3;
    localparam int NV = 2;
    localparam int N  = NB * NV;
    localparam int BW = $clog2(N);

    logic          clk = 1'b0;
    logic          n_rst;
    logic [N-1:0]  not_idle;
    logic [N-1:0]  flit_sent;
    logic          clear_req;
    logic          rd_req;
    logic [BW-1:0] rd_buf;
    logic [2:0]    rd_sel;
    logic          rd_valid;
    logic [31:0]   rd_data;
    logic          rd_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          b;
        int          sel;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    switch_perf_counters #(
        .NUM_BUFFERS(NB),
        .NUM_VCS(NV),
        .LAT_WIDTH(16),
        .CNT_WIDTH(32)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .not_idle(not_idle),
        .flit_sent(flit_sent),
        .clear_req(clear_req),
        .rd_req(rd_req),
        .rd_buf(rd_buf),
        .rd_sel(rd_sel),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_read(input int b, input int sel, input logic [31:0] exp, input logic exp_err);
        string name;
        name = $sformatf("rd q%0d sel%0d", b, sel);
        @(negedge clk);
        rd_req = 1'b1;
        rd_buf = BW'(b);
        rd_sel = 3'(sel);
        @(negedge clk);
        rd_req = 1'b0;
        check({name, " valid"}, 32'(rd_valid), 32'd1);
        check({name, " data"}, rd_data, exp);
        check({name, " err"}, 32'(rd_err), 32'(exp_err));
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int k = lo; k < hi; k++)
            do_read(vecs[k].b, vecs[k].sel, vecs[k].exp, vecs[k].exp_err);
    endtask

    task automatic pkt(input int q, input int lat, input int flits);
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            not_idle[q]  = 1'b1;
            flit_sent[q] = (c < flits);
        end
        @(negedge clk);
        not_idle[q]  = 1'b0;
        flit_sent[q] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_rst = 1'b0; not_idle = '0; flit_sent = '0; clear_req = 1'b0;
        rd_req = 1'b0; rd_buf = '0; rd_sel = '0;

        // Table: [0..14) basic, [14..27) after clear, [27..31) saturation, [31..37) after mid-packet reset
        vecs.push_back('{0, 0, 32'd1, 1'b0});
        vecs.push_back('{0, 1, 32'd4, 1'b0});
        vecs.push_back('{0, 2, 32'd6, 1'b0});
        vecs.push_back('{0, 3, 32'd6, 1'b0});
        vecs.push_back('{0, 4, 32'd6, 1'b0});
        vecs.push_back('{1, 0, 32'd2, 1'b0});
        vecs.push_back('{1, 1, 32'd4, 1'b0});
        vecs.push_back('{1, 2, 32'd12, 1'b0});
        vecs.push_back('{1, 3, 32'd3, 1'b0});
        vecs.push_back('{1, 4, 32'd9, 1'b0});
        vecs.push_back('{2, 0, 32'd0, 1'b0});
        vecs.push_back('{2, 3, 32'hFFFF, 1'b0});
        vecs.push_back('{2, 4, 32'd0, 1'b0});
        vecs.push_back('{5, 3, 32'hFFFF, 1'b0});

        vecs.push_back('{0, 0, 32'd0, 1'b0});
        vecs.push_back('{0, 1, 32'd0, 1'b0});
        vecs.push_back('{0, 2, 32'd0, 1'b0});
        vecs.push_back('{0, 3, 32'hFFFF, 1'b0});
        vecs.push_back('{0, 4, 32'd0, 1'b0});
        vecs.push_back('{1, 0, 32'd0, 1'b0});
        vecs.push_back('{1, 2, 32'd0, 1'b0});
        vecs.push_back('{1, 3, 32'hFFFF, 1'b0});
        vecs.push_back('{3, 0, 32'd1, 1'b0});
        vecs.push_back('{3, 1, 32'd1, 1'b0});
        vecs.push_back('{3, 2, 32'd10, 1'b0});
        vecs.push_back('{3, 3, 32'd10, 1'b0});
        vecs.push_back('{3, 4, 32'd10, 1'b0});

        vecs.push_back('{4, 4, 32'hFFFF, 1'b0});
        vecs.push_back('{4, 3, 32'hFFFF, 1'b0});
        vecs.push_back('{4, 2, 32'hFFFF, 1'b0});
        vecs.push_back('{4, 1, 32'd1, 1'b0});

        vecs.push_back('{5, 0, 32'd1, 1'b0});
        vecs.push_back('{5, 2, 32'd3, 1'b0});
        vecs.push_back('{5, 4, 32'd3, 1'b0});
        vecs.push_back('{4, 0, 32'd0, 1'b0});
        vecs.push_back('{4, 3, 32'hFFFF, 1'b0});
        vecs.push_back('{3, 1, 32'd0, 1'b0});

        repeat (3) @(negedge clk);
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset rd_data", rd_data, 32'd0);
        check("reset rd_err", 32'(rd_err), 32'd0);
        n_rst = 1'b1;

        pkt(0, 6, 4);
        pkt(1, 3, 2);
        pkt(1, 9, 2);
        pkt(2, 4, 0);
        run_vecs(0, 14);

        // q0 ends (lat 5, 1 flit) in the clear cycle; q3 stays in flight across it
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 6) begin
                check("clr-cycle read valid", 32'(rd_valid), 32'd1);
                check("clr-cycle read old value", rd_data, 32'd1);
            end
            not_idle[3]  = 1'b1;
            flit_sent[3] = (c == 0);
            not_idle[0]  = (c < 5);
            flit_sent[0] = (c == 0);
            clear_req    = (c == 5);
            rd_req       = (c == 5);
            rd_buf       = '0;
            rd_sel       = 3'd0;
        end
        @(negedge clk);
        not_idle = '0; flit_sent = '0; clear_req = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        run_vecs(14, 27);

        // back-to-back reads, last two erroneous
        @(negedge clk);
        rd_req = 1'b1; rd_buf = BW'(0); rd_sel = 3'd0;
        @(negedge clk);
        check("b2b0 valid", 32'(rd_valid), 32'd1);
        check("b2b0 err", 32'(rd_err), 32'd0);
        check("b2b0 data", rd_data, 32'd0);
        rd_buf = BW'(1); rd_sel = 3'd5;
        @(negedge clk);
        check("b2b1 valid", 32'(rd_valid), 32'd1);
        check("b2b1 err", 32'(rd_err), 32'd1);
        check("b2b1 data", rd_data, 32'd0);
        rd_buf = BW'(N); rd_sel = 3'd0;
        @(negedge clk);
        check("b2b2 valid", 32'(rd_valid), 32'd1);
        check("b2b2 err", 32'(rd_err), 32'd1);
        check("b2b2 data", rd_data, 32'd0);
        rd_req = 1'b0;
        @(negedge clk);
        check("idle valid", 32'(rd_valid), 32'd0);
        check("idle data", rd_data, 32'd0);
        check("idle err", 32'(rd_err), 32'd0);

        // 0xFFFE + 5 busy cycles: latency saturates at 0xFFFF
        pkt(4, 65539, 1);
        run_vecs(27, 31);

        // reset mid-packet on q5; packet records only post-reset cycles
        @(negedge clk);
        not_idle[5] = 1'b1; flit_sent[5] = 1'b1;
        @(negedge clk);
        n_rst = 1'b0; rd_req = 1'b1; rd_buf = BW'(3); rd_sel = 3'd1;
        @(negedge clk);
        @(negedge clk);
        check("mid-rst rd_valid", 32'(rd_valid), 32'd0);
        check("mid-rst rd_data", rd_data, 32'd0);
        check("mid-rst rd_err", 32'(rd_err), 32'd0);
        rd_req = 1'b0;
        n_rst = 1'b1; flit_sent[5] = 1'b1;
        @(negedge clk);
        flit_sent[5] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        not_idle[5] = 1'b0;
        @(negedge clk);
        run_vecs(31, 37);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
